ir_nec_rx: RTL

Parametrised NEC infrared frame receiver, the successor to the fixed-rate IR driver. It decodes address and command from a demodulated IR receiver output and checks both bytes against their inverses. It runs at any system clock through a divider parameter and supports either input polarity. Decoded codes go to the user-logic layer as a one-cycle strobe with held data.

---
 rtl/ir_pkg.sv | 32 +++
 rtl/ir_tick_gen.sv | 27 ++
 rtl/ir_nec_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types and timing windows (in sample ticks) for the NEC IR receiver.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP,
        S_RPT_STOP
    } ir_state_t;

    localparam logic [7:0] LEAD_MARK_MIN  = 8'd56;
    localparam logic [7:0] LEAD_MARK_MAX  = 8'd72;
    localparam logic [7:0] LEAD_SPACE_MIN = 8'd28;
    localparam logic [7:0] LEAD_SPACE_MAX = 8'd36;
    localparam logic [7:0] RPT_SPACE_MIN  = 8'd12;
    localparam logic [7:0] RPT_SPACE_MAX  = 8'd20;

    localparam int UNIT_TICKS      = 4;
    localparam int ONE_SPACE_TICKS = 12;

    localparam logic [7:0] WIDTH_SAT = 8'd255;

    function automatic logic in_window(input logic [7:0] val,
                                       input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks (TICK_DIV >= 2).
module ir_tick_gen #(
    parameter int TICK_DIV = 7031
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame receiver: decodes address/command and checks both inverse bytes.
// Define IR_REPEAT_EN to accept NEC repeat codes and drive repeat_valid.
module ir_nec_rx
    import ir_pkg::*;
#(
    parameter int TICK_DIV   = 7031,
    parameter int ACTIVE_LOW = 1,
    parameter int TOL        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_in,
    output logic       code_valid,
    output logic [7:0] address,
    output logic [7:0] command,
    output logic       repeat_valid,
    output logic       frame_err
);
    localparam logic [7:0] BIT_MIN  = 8'(UNIT_TICKS - TOL);
    localparam logic [7:0] BIT_MAX  = 8'(UNIT_TICKS + TOL);
    localparam logic [7:0] ONE_MIN  = 8'(ONE_SPACE_TICKS - TOL);
    localparam logic [7:0] ONE_MAX  = 8'(ONE_SPACE_TICKS + TOL);
    localparam logic       IDLE_LVL = (ACTIVE_LOW != 0);

    logic        tick;
    logic        ir_meta, ir_sync;
    logic        mark, mark_d, mark_edge, mark_rise;
    logic [7:0]  width;
    ir_state_t   state, state_n, reject_state;
    logic [4:0]  bit_idx, bit_idx_n;
    logic [31:0] shreg, shreg_n;
    logic        cv_n, fe_n;
    logic        unit_ok, one_ok, lead_mark_ok, lead_space_ok, inverse_ok;

    ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Synchronizer resets to the idle line level so no edge is seen after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_meta <= IDLE_LVL;
            ir_sync <= IDLE_LVL;
            mark_d  <= 1'b0;
        end else begin
            ir_meta <= ir_in;
            ir_sync <= ir_meta;
            mark_d  <= mark;
        end
    end

    assign mark      = ir_sync ^ IDLE_LVL;
    assign mark_edge = mark ^ mark_d;
    assign mark_rise = mark_edge & mark;

    always_ff @(posedge clk) begin
        if (reset || mark_edge)
            width <= '0;
        else if (tick && width != WIDTH_SAT)
            width <= width + 1'b1;
    end

    assign unit_ok       = in_window(width, BIT_MIN, BIT_MAX);
    assign one_ok        = in_window(width, ONE_MIN, ONE_MAX);
    assign lead_mark_ok  = in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX);
    assign lead_space_ok = in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
    assign inverse_ok    = (shreg[15:8] == ~shreg[7:0]) && (shreg[31:24] == ~shreg[23:16]);
    // A rejected rising edge is itself a burst start, so it may be a new leader.
    assign reject_state  = mark_rise ? S_LEAD_MARK : S_IDLE;

`ifdef IR_REPEAT_EN
    logic rv_n;
    logic frame_seen;
    logic rpt_space_ok;
    assign rpt_space_ok = in_window(width, RPT_SPACE_MIN, RPT_SPACE_MAX);
`endif

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        cv_n      = 1'b0;
        fe_n      = 1'b0;
`ifdef IR_REPEAT_EN
        rv_n      = 1'b0;
`endif
        if (mark_edge) begin
            case (state)
                S_IDLE: begin
                    if (mark_rise) state_n = S_LEAD_MARK;
                end
                S_LEAD_MARK: begin
                    if (lead_mark_ok) state_n = S_LEAD_SPACE;
                    else begin fe_n = 1'b1; state_n = reject_state; end
                end
                S_LEAD_SPACE: begin
                    if (lead_space_ok) begin
                        state_n   = S_BIT_MARK;
                        bit_idx_n = '0;
                    end
`ifdef IR_REPEAT_EN
                    else if (rpt_space_ok) state_n = S_RPT_STOP;
`endif
                    else begin fe_n = 1'b1; state_n = reject_state; end
                end
                S_BIT_MARK: begin
                    if (unit_ok) state_n = S_BIT_SPACE;
                    else begin fe_n = 1'b1; state_n = reject_state; end
                end
                S_BIT_SPACE: begin
                    if (unit_ok || one_ok) begin
                        shreg_n   = {!unit_ok, shreg[31:1]};
                        bit_idx_n = bit_idx + 1'b1;
                        state_n   = (bit_idx == 5'd31) ? S_STOP : S_BIT_MARK;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = reject_state;
                    end
                end
                S_STOP: begin
                    if (unit_ok) begin
                        cv_n    = inverse_ok;
                        fe_n    = !inverse_ok;
                        state_n = S_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = reject_state;
                    end
                end
`ifdef IR_REPEAT_EN
                S_RPT_STOP: begin
                    if (unit_ok) begin
                        rv_n    = frame_seen;
                        fe_n    = !frame_seen;
                        state_n = S_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = reject_state;
                    end
                end
`endif
                default: state_n = S_IDLE;
            endcase
        end else if (state != S_IDLE && width == WIDTH_SAT) begin
            fe_n    = 1'b1;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            address    <= 8'h00;
            command    <= 8'h00;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            code_valid <= cv_n;
            frame_err  <= fe_n;
            if (cv_n) begin
                address <= shreg[7:0];
                command <= shreg[23:16];
            end
        end
    end

`ifdef IR_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_seen   <= 1'b0;
            repeat_valid <= 1'b0;
        end else begin
            repeat_valid <= rv_n;
            if (cv_n) frame_seen <= 1'b1;
        end
    end
`else
    assign repeat_valid = 1'b0;
`endif

endmodule
